// File: rtl/trs80_pkg.sv
// Shared TRS-80 Model I constants: I/O port numbers, cassette port bit
// positions and cassette output level encodings.
package trs80_pkg;

  localparam logic [7:0] PORT_CASSETTE = 8'hFF;

  localparam int CAS_LVL_LO = 0;
  localparam int CAS_LVL_HI = 1;
  localparam int CAS_MOTOR  = 2;
  localparam int CAS_MODE32 = 3;
  localparam int CAS_LATCH  = 7;

  localparam logic [1:0] LVL_ZERO = 2'b00;
  localparam logic [1:0] LVL_POS  = 2'b01;
  localparam logic [1:0] LVL_NEG  = 2'b10;

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC: 16-bit code in, 1-bit stream out whose
// long-run duty equals code/65536.
module sigma_delta_dac (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] code,
  output logic        bit_out
);

  logic [16:0] acc_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg <= 17'd0;
      bit_out <= 1'b0;
    end else begin
      acc_reg <= {1'b0, acc_reg[15:0]} + {1'b0, code};
      bit_out <= acc_reg[16];
    end
  end

endmodule

// File: rtl/cassette_port.sv
// TRS-80 Model I cassette port at I/O FFh: OUT sets level/motor/mode32,
// IN returns the filtered cassette-pulse latch; output level drives a DAC.
module cassette_port
  import trs80_pkg::*;
#(
  parameter int          FILTER_LEN    = 8,
  parameter int          LED_HOLD      = 200000,
  parameter logic [15:0] AUDIO_HIGH    = 16'hC000,
  parameter logic [15:0] AUDIO_MID     = 16'h8000,
  parameter logic [15:0] AUDIO_LOW     = 16'h4000,
  parameter bit          GATE_ON_MOTOR = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_dout,
  output logic       io_cs_n,
  output logic [7:0] io_dout,
  input  logic       cas_in,
  output logic       cas_motor,
  output logic       mode32,
  output logic       audio_out,
  output logic       led
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sel;
  logic             wr_act;
  logic             wr_act_d_reg;
  logic             wr_pulse;
  logic [1:0]       out_lvl_reg;
  logic             motor_reg;
  logic             mode32_reg;
  logic             latch_reg;
  logic [1:0]       sync_reg;
  logic             filt_lvl_reg;
  logic             filt_d_reg;
  logic [CNT_W-1:0] filt_cnt_reg;
  logic             filt_rise;
  logic             latch_set;
  logic             lvl_change;
  logic             led_load;
  logic [17:0]      led_cnt_reg;
  logic             led_reg;
  logic [15:0]      audio_code;
  logic             unused_dout;

  assign unused_dout = ^cpu_dout[7:4];

  assign sel      = (cpu_addr == PORT_CASSETTE) && !cpu_iorq_n;
  assign io_cs_n  = !(sel && !cpu_rd_n);
  assign wr_act   = sel && !cpu_wr_n;
  assign wr_pulse = wr_act && !wr_act_d_reg;

  always_comb begin
    io_dout            = 8'b0011_1111;
    io_dout[CAS_LATCH] = latch_reg;
    io_dout[6]         = mode32_reg;
  end

  assign filt_rise  = filt_lvl_reg && !filt_d_reg;
  assign latch_set  = filt_rise && (!GATE_ON_MOTOR || motor_reg);
  assign lvl_change = wr_pulse && (cpu_dout[CAS_LVL_HI:CAS_LVL_LO] != out_lvl_reg);
  assign led_load   = lvl_change || latch_set;

  // wr_act_d resets high so a write still held across reset release is not
  // mistaken for a new OUT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_act_d_reg <= 1'b1;
      out_lvl_reg  <= LVL_ZERO;
      motor_reg    <= 1'b0;
      mode32_reg   <= 1'b0;
      latch_reg    <= 1'b0;
    end else begin
      wr_act_d_reg <= wr_act;
      if (wr_pulse) begin
        out_lvl_reg <= cpu_dout[CAS_LVL_HI:CAS_LVL_LO];
        motor_reg   <= cpu_dout[CAS_MOTOR];
        mode32_reg  <= cpu_dout[CAS_MODE32];
      end
      // A pulse arriving with the clearing write must still be seen.
      if (latch_set) begin
        latch_reg <= 1'b1;
      end else if (wr_pulse) begin
        latch_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= 2'b00;
      filt_lvl_reg <= 1'b0;
      filt_d_reg   <= 1'b0;
      filt_cnt_reg <= '0;
    end else begin
      sync_reg   <= {sync_reg[0], cas_in};
      filt_d_reg <= filt_lvl_reg;
      if (sync_reg[1] == filt_lvl_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
        filt_lvl_reg <= sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // led is registered so it is lit in the load cycle and for LED_HOLD cycles total.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_cnt_reg <= 18'd0;
      led_reg     <= 1'b0;
    end else begin
      led_reg <= led_load || (led_cnt_reg != 18'd0);
      if (led_load) begin
        led_cnt_reg <= 18'(LED_HOLD - 1);
      end else if (led_cnt_reg != 18'd0) begin
        led_cnt_reg <= led_cnt_reg - 18'd1;
      end
    end
  end

  always_comb begin
    audio_code = AUDIO_MID;
    case (out_lvl_reg)
      LVL_POS: audio_code = AUDIO_HIGH;
      LVL_NEG: audio_code = AUDIO_LOW;
      default: audio_code = AUDIO_MID;
    endcase
  end

  sigma_delta_dac u_dac (
    .clock   (clock),
    .reset_n (reset_n),
    .code    (audio_code),
    .bit_out (audio_out)
  );

  assign cas_motor = motor_reg;
  assign mode32    = mode32_reg;
  assign led       = led_reg;

endmodule

// File: tb/tb_cassette_port.sv
// Directed self-checking bench for cassette_port (LED hold shortened to 200).
module tb_cassette_port;

  localparam int HOLD = 200;

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] cpu_addr  = 8'h00;
  logic       cpu_iorq_n = 1'b1;
  logic       cpu_rd_n  = 1'b1;
  logic       cpu_wr_n  = 1'b1;
  logic [7:0] cpu_dout  = 8'h00;
  logic       io_cs_n;
  logic [7:0] io_dout;
  logic       cas_in    = 1'b0;
  logic       cas_motor;
  logic       mode32;
  logic       audio_out;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int led_cycles = 0;
  int ones;

  cassette_port #(.LED_HOLD(HOLD)) dut (
    .clock      (cpu_clock),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_dout   (cpu_dout),
    .io_cs_n    (io_cs_n),
    .io_dout    (io_dout),
    .cas_in     (cas_in),
    .cas_motor  (cas_motor),
    .mode32     (mode32),
    .audio_out  (audio_out),
    .led        (led)
  );

  always #5 cpu_clock = ~cpu_clock;

  always @(posedge cpu_clock) if (dut.wr_pulse) pulse_cnt++;
  always @(negedge cpu_clock) if (led) led_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
    $display("check %-16s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic out_ff(input logic [7:0] data, input int hold);
    cpu_addr   = 8'hFF;
    cpu_dout   = data;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    repeat (hold) @(posedge cpu_clock);
    @(negedge cpu_clock);
    cpu_wr_n   = 1'b1;
    cpu_iorq_n = 1'b1;
  endtask

  task automatic in_ff(output logic [7:0] data, output logic cs);
    cpu_addr   = 8'hFF;
    cpu_iorq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    #1;
    data = io_dout;
    cs   = io_cs_n;
    cpu_rd_n   = 1'b1;
    cpu_iorq_n = 1'b1;
  endtask

  task automatic duty(output int cnt);
    cnt = 0;
    repeat (4096) begin
      @(negedge cpu_clock);
      if (audio_out) cnt++;
    end
  endtask

  task automatic cas_pulse(input int len);
    @(negedge cpu_clock);
    cas_in = 1'b1;
    repeat (len) @(negedge cpu_clock);
    cas_in = 1'b0;
    repeat (20) @(negedge cpu_clock);
  endtask

  initial begin
    logic [7:0] rd;
    logic       cs;

    // Reset state
    #1;
    check("rst_motor", cas_motor, 1'b0);
    check("rst_audio", audio_out, 1'b0);
    check("idle_cs_n", io_cs_n, 1'b1);
    repeat (3) @(negedge cpu_clock);
    reset_n = 1'b1;
    repeat (3) @(negedge cpu_clock);
    in_ff(rd, cs);
    check("idle_in", rd, 8'h3F);
    check("in_cs_n", cs, 1'b0);
    check("idle_led", led, 1'b0);
    duty(ones);
    check_range("duty_mid", ones, 2047, 2049);

    // OUT 05 with WR_n held 3 cycles
    @(negedge cpu_clock);
    pulse_cnt  = 0;
    led_cycles = 0;
    out_ff(8'h05, 3);
    check("wr_pulses", pulse_cnt, 1);
    check("motor_on", cas_motor, 1'b1);
    check("mode32_0", mode32, 1'b0);
    check("out_lvl_01", dut.out_lvl_reg, 2'b01);
    check("led_on", led, 1'b1);
    repeat (300) @(negedge cpu_clock);
    check("led_hold", led_cycles, HOLD);
    check("led_off", led, 1'b0);
    duty(ones);
    check_range("duty_high", ones, 3071, 3073);

    // Motor on: cas_in high 20 cycles, latch on the 11th edge
    @(negedge cpu_clock);
    cas_in = 1'b1;
    repeat (10) @(posedge cpu_clock);
    #1 check("latch_at_10", io_dout[7], 1'b0);
    @(posedge cpu_clock);
    #1 check("latch_at_11", io_dout[7], 1'b1);
    repeat (9) @(negedge cpu_clock);
    cas_in = 1'b0;
    repeat (20) @(negedge cpu_clock);
    in_ff(rd, cs);
    check("in_latched", rd, 8'hBF);
    @(negedge cpu_clock);
    out_ff(8'h04, 1);
    in_ff(rd, cs);
    check("in_cleared", rd, 8'h3F);

    // Short pulse rejected; motor-off pulse ignored
    cas_pulse(5);
    check("short_pulse", io_dout[7], 1'b0);
    @(negedge cpu_clock);
    out_ff(8'h00, 1);
    cas_pulse(20);
    check("motor_off", io_dout[7], 1'b0);

    // Filtered edge coincides with the write pulse: set wins
    @(negedge cpu_clock);
    out_ff(8'h04, 1);
    cas_in = 1'b1;
    repeat (10) @(posedge cpu_clock);
    @(negedge cpu_clock);
    check("pre_collide", io_dout[7], 1'b0);
    out_ff(8'h05, 1);
    check("collide_latch", io_dout[7], 1'b1);
    check("collide_lvl", dut.out_lvl_reg, 2'b01);
    repeat (9) @(negedge cpu_clock);
    cas_in = 1'b0;
    repeat (20) @(negedge cpu_clock);

    // Reset in the middle of an OUT with latch and mode32 set
    out_ff(8'h0D, 1);
    cas_pulse(20);
    check("pre_rst_in", io_dout, 8'hFF);
    cpu_addr   = 8'hFF;
    cpu_dout   = 8'h0A;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_dout", io_dout, 8'h3F);
    check("mid_rst_motor", cas_motor, 1'b0);
    check("mid_rst_mode32", mode32, 1'b0);
    check("mid_rst_led", led, 1'b0);
    check("mid_rst_audio", audio_out, 1'b0);
    @(posedge cpu_clock);
    @(negedge cpu_clock);
    pulse_cnt = 0;
    reset_n = 1'b1;
    repeat (3) @(posedge cpu_clock);
    @(negedge cpu_clock);
    check("rel_pulses", pulse_cnt, 0);
    check("rel_mode32", mode32, 1'b0);
    check("rel_motor", cas_motor, 1'b0);
    check("rel_lvl", dut.out_lvl_reg, 2'b00);
    check("rel_led", led, 1'b0);
    cpu_wr_n   = 1'b1;
    cpu_iorq_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
